// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the
// instruction memory address and fills the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AlignErr,
  output logic        FetchFault,
  output logic [31:0] FetchCount
);

  localparam int unsigned WORD_IDX_W = 30;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        out_of_range;

  // Memory is addressed straight from the PC register
  assign IMemAddress = PC;

  // Next-PC candidates; a taken branch beats a jump when both resolve
  always_comb begin
    pc_plus4        = PC + 32'd4;
    redirect        = BranchTaken | Jump;
    redirect_target = BranchTaken ? BranchTarget : JumpTarget;
    out_of_range    = PC[31:2] >= WORD_IDX_W'(IMEM_WORDS);
  end

  // PC, IF/ID register and sticky status; reset > redirect > stall > advance
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC                <= RESET_PC;
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_PCPlus4     <= 32'd0;
      IF_ID_Valid       <= 1'b0;
      AlignErr          <= 1'b0;
      FetchFault        <= 1'b0;
      FetchCount        <= 32'd0;
    end else if (redirect) begin
      // Redirect squashes the wrong-path fetch, even while stalled
      PC                <= {redirect_target[31:2], 2'b00};
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_PCPlus4     <= 32'd0;
      IF_ID_Valid       <= 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        AlignErr <= 1'b1;
      end
    end else if (!Stall) begin
      // PC keeps advancing out of range so a later redirect can recover
      PC <= pc_plus4;
      if (out_of_range) begin
        IF_ID_Instruction <= NOP_WORD;
        IF_ID_PCPlus4     <= 32'd0;
        IF_ID_Valid       <= 1'b0;
        FetchFault        <= 1'b1;
      end else begin
        IF_ID_Instruction <= IMemInstruction;
        IF_ID_PCPlus4     <= pc_plus4;
        IF_ID_Valid       <= 1'b1;
        FetchCount        <= FetchCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-edge vector table plus a
// hand-written check that outputs only move on clock edges.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        AlignErr;
  logic        FetchFault;
  logic [31:0] FetchCount;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [128];

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(128),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Stall            (Stall),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .Jump             (Jump),
    .JumpTarget       (JumpTarget),
    .IMemAddress      (IMemAddress),
    .IMemInstruction  (IMemInstruction),
    .PC               (PC),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .AlignErr         (AlignErr),
    .FetchFault       (FetchFault),
    .FetchCount       (FetchCount)
  );

  always #5 Clk = ~Clk;

  // Combinational instruction memory, word i holds i*4, indexed by addr[8:2]
  assign IMemInstruction = mem[IMemAddress[8:2]];

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        a;
    logic        f;
    logic [31:0] c;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] brt,
                              logic jmp, logic [31:0] jt, logic [31:0] pc,
                              logic [31:0] ins, logic [31:0] p4, logic v,
                              logic a, logic f, logic [31:0] c);
    vec_t r;
    r.rst = rst; r.stall = stall; r.br = br; r.brt = brt; r.jmp = jmp; r.jt = jt;
    r.pc = pc; r.ins = ins; r.p4 = p4; r.v = v; r.a = a; r.f = f; r.c = c;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    Rst = t.rst; Stall = t.stall; BranchTaken = t.br; BranchTarget = t.brt;
    Jump = t.jmp; JumpTarget = t.jt;
  endtask

  logic [31:0] snap_pc, snap_ins, snap_p4, snap_c;
  logic        snap_v;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
    Rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0;
    Jump = 1'b0; JumpTarget = 32'd0;

    //               rst st br brt           jmp jt            pc            ins           p4            v  a  f  c
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0)); // 0 reset
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 0, 0, 1)); // 1 free run
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 0, 0, 2));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'hC,        1, 0, 0, 3));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC,        32'h10,       1, 0, 0, 4));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0)); // 5 reset
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 0, 0, 2));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 0, 0, 2)); // 8 stall x3
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 0, 0, 2));
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h8,        1, 0, 0, 2));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'hC,        1, 0, 0, 3)); // 11 resume at 8
    vq.push_back(mk(0, 1, 1, 32'h40,       1, 32'h80,       32'h40,       32'h0,        32'h0,        0, 0, 0, 3)); // 12 branch wins
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       32'h40,       32'h44,       1, 0, 0, 4)); // 13 word 16
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 32'h22,       32'h20,       32'h0,        32'h0,        0, 1, 0, 4)); // 14 misaligned jump
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h24,       32'h20,       32'h24,       1, 1, 0, 5));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1FC,      32'h1FC,      32'h0,        32'h0,        0, 1, 0, 5)); // 16 jump to last word
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h200,      32'h1FC,      32'h200,      1, 1, 0, 6));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h204,      32'h0,        32'h0,        0, 1, 1, 6)); // 18 out of range
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h208,      32'h0,        32'h0,        0, 1, 1, 6));
    vq.push_back(mk(0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 1, 6)); // 20 recover
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1, 1, 7));
    vq.push_back(mk(1, 1, 1, 32'h40,       0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0)); // 22 reset wins
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 32'h10,       1, 32'h33,       32'h10,       32'h0,        32'h0,        0, 0, 0, 1)); // 24 losing target ignored
    vq.push_back(mk(0, 1, 1, 32'h11,       0, 32'h0,        32'h10,       32'h0,        32'h0,        0, 1, 0, 1)); // 25 misaligned branch
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,        32'h0,        0, 1, 0, 1)); // 26 stall holds bubble
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h14,       32'h10,       32'h14,       1, 1, 0, 2));
    vq.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 1, 0, 2)); // 28 top of space
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 1, 2)); // 29 wraps to 0
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h4,        1, 1, 1, 3));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clk);
      drive(vq[i]);
      @(posedge Clk);
      #1;
      chk("pc",      i, PC,                vq[i].pc);
      chk("imemadr", i, IMemAddress,       vq[i].pc);
      chk("instr",   i, IF_ID_Instruction, vq[i].ins);
      chk("pcplus4", i, IF_ID_PCPlus4,     vq[i].p4);
      chk("valid",   i, 32'(IF_ID_Valid),  32'(vq[i].v));
      chk("alignerr",i, 32'(AlignErr),     32'(vq[i].a));
      chk("fault",   i, 32'(FetchFault),   32'(vq[i].f));
      chk("count",   i, FetchCount,        vq[i].c);
    end

    // Redirect/stall inputs toggled between edges must not disturb outputs
    @(negedge Clk);
    Rst = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    snap_pc = PC; snap_ins = IF_ID_Instruction; snap_p4 = IF_ID_PCPlus4;
    snap_v = IF_ID_Valid; snap_c = FetchCount;
    BranchTaken = 1'b1; BranchTarget = 32'h80; #1;
    Jump = 1'b1; JumpTarget = 32'h100; Stall = 1'b1; #1;
    chk("mid_pc",    100, PC,                snap_pc);
    chk("mid_instr", 100, IF_ID_Instruction, snap_ins);
    chk("mid_p4",    100, IF_ID_PCPlus4,     snap_p4);
    chk("mid_valid", 100, 32'(IF_ID_Valid),  32'(snap_v));
    chk("mid_count", 100, FetchCount,        snap_c);
    BranchTaken = 1'b0; Jump = 1'b0; Stall = 1'b0;
    // Sequential edge from PC=4: captures word 1 (value 4)
    @(posedge Clk);
    #1;
    chk("seq_pc",    101, PC,                32'h8);
    chk("seq_instr", 101, IF_ID_Instruction, 32'h4);
    chk("seq_p4",    101, IF_ID_PCPlus4,     32'h8);
    chk("seq_count", 101, FetchCount,        32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Bound the total run in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, tests %0d", tests);
    $fatal(1);
  end

endmodule
